// File: rtl/bus_arbiter_xbar.sv
// bus_arbiter_xbar: two-master round-robin arbiter and slave decoder
// with per-access timeout and registered req/ack/err handshakes.
//
// Ports:
//   m0_*/m1_*   master ports (req held until ack; ack/err/rdata 1-cycle pulse)
//   s_req       one-hot slave select (slot 0 = RAM, 1..NS = peripherals)
//   s_we/s_addr/s_wdata  latched request, stable during the access
//   s_rdata/s_ack        slave read data (flattened) and completions
//   busy/grant  transaction in flight / owner of current or last access
module bus_arbiter_xbar #(
    parameter int              AW          = 16,
    parameter int              DW          = 16,
    parameter int              NS          = 6,
    parameter logic [AW-9:0]   PERIPH_PAGE = 8'hFF,
    parameter int              TIMEOUT     = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               m0_req,
    input  logic               m0_we,
    input  logic [AW-1:0]      m0_addr,
    input  logic [DW-1:0]      m0_wdata,
    output logic [DW-1:0]      m0_rdata,
    output logic               m0_ack,
    output logic               m0_err,
    input  logic               m1_req,
    input  logic               m1_we,
    input  logic [AW-1:0]      m1_addr,
    input  logic [DW-1:0]      m1_wdata,
    output logic [DW-1:0]      m1_rdata,
    output logic               m1_ack,
    output logic               m1_err,
    output logic [NS:0]        s_req,
    output logic               s_we,
    output logic [AW-1:0]      s_addr,
    output logic [DW-1:0]      s_wdata,
    input  logic [(NS+1)*DW-1:0] s_rdata,
    input  logic [NS:0]        s_ack,
    output logic               busy,
    output logic               grant
);

    localparam int         NSL     = NS + 1;
    localparam logic [4:0] NS_LIM  = 5'(NS);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t           state_q, state_d;
    logic [NSL-1:0]   s_req_q, s_req_d;
    logic             s_we_q, s_we_d;
    logic [AW-1:0]    s_addr_q, s_addr_d;
    logic [DW-1:0]    s_wdata_q, s_wdata_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             grant_q, grant_d;
    logic             rr_q, rr_d;
    logic             busy_q, busy_d;
    logic [1:0]       ack_q, ack_d;
    logic [1:0]       err_q, err_d;
    logic [DW-1:0]    m0_rdata_q, m0_rdata_d;
    logic [DW-1:0]    m1_rdata_q, m1_rdata_d;

    logic             req_any;
    logic             sel;
    logic [AW-1:0]    sel_addr;
    logic             mapped;
    logic [3:0]       slot;
    logic [NSL-1:0]   slot_oh;
    logic             hit;
    logic [DW-1:0]    hit_rdata;
    logic             tmo;
    logic             resp_v;
    logic             resp_err;
    logic             resp_to;
    logic [DW-1:0]    resp_rdata;

    // Arbitration and address decode; rr_q remembers the last winner.
    always_comb begin : decode
        req_any  = m0_req | m1_req;
        sel      = (m0_req & m1_req) ? ~rr_q : m1_req;
        sel_addr = sel ? m1_addr : m0_addr;
        mapped   = 1'b1;
        slot     = '0;
        if (sel_addr[AW-1:8] == PERIPH_PAGE) begin
            mapped = {1'b0, sel_addr[7:4]} < NS_LIM;
            slot   = sel_addr[7:4] + 4'd1;
        end
        for (int k = 0; k < NSL; k++) begin
            slot_oh[k] = (slot == 4'(k));
        end
        // s_req_q is one-hot on the active slot, so it masks s_ack/s_rdata.
        hit       = |(s_ack & s_req_q);
        hit_rdata = '0;
        for (int k = 0; k < NSL; k++) begin
            if (s_req_q[k]) begin
                hit_rdata = s_rdata[k*DW +: DW];
            end
        end
        tmo = (cnt_q == TO_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            s_req_q    <= '0;
            s_we_q     <= 1'b0;
            s_addr_q   <= '0;
            s_wdata_q  <= '0;
            cnt_q      <= '0;
            grant_q    <= 1'b0;
            rr_q       <= 1'b1;
            busy_q     <= 1'b0;
            ack_q      <= '0;
            err_q      <= '0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            s_req_q    <= s_req_d;
            s_we_q     <= s_we_d;
            s_addr_q   <= s_addr_d;
            s_wdata_q  <= s_wdata_d;
            cnt_q      <= cnt_d;
            grant_q    <= grant_d;
            rr_q       <= rr_d;
            busy_q     <= busy_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req_any) begin
                    state_d = mapped ? ACCESS : RESP;
                end
            end
            ACCESS: begin
                if (hit || tmo) begin
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin : outputs
        s_req_d    = '0;
        s_we_d     = s_we_q;
        s_addr_d   = s_addr_q;
        s_wdata_d  = s_wdata_q;
        cnt_d      = cnt_q;
        grant_d    = grant_q;
        rr_d       = rr_q;
        resp_v     = 1'b0;
        resp_err   = 1'b0;
        resp_to    = grant_q;
        resp_rdata = '0;
        unique case (state_q)
            IDLE: begin
                if (req_any) begin
                    grant_d   = sel;
                    rr_d      = sel;
                    resp_to   = sel;
                    s_we_d    = sel ? m1_we : m0_we;
                    s_addr_d  = sel_addr;
                    s_wdata_d = sel ? m1_wdata : m0_wdata;
                    cnt_d     = '0;
                    if (mapped) begin
                        s_req_d = slot_oh;
                    end else begin
                        resp_v   = 1'b1;
                        resp_err = 1'b1;
                    end
                end
            end
            ACCESS: begin
                // A same-cycle ack wins over the timeout.
                if (hit) begin
                    resp_v     = 1'b1;
                    resp_rdata = s_we_q ? '0 : hit_rdata;
                end else if (tmo) begin
                    resp_v   = 1'b1;
                    resp_err = 1'b1;
                end else begin
                    s_req_d = s_req_q;
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            default: ;
        endcase
        ack_d      = {resp_v & resp_to, resp_v & ~resp_to};
        err_d      = {resp_err & resp_to, resp_err & ~resp_to};
        m0_rdata_d = (resp_v & ~resp_to) ? resp_rdata : '0;
        m1_rdata_d = (resp_v & resp_to) ? resp_rdata : '0;
        busy_d     = (state_d != IDLE);
    end

    assign m0_ack   = ack_q[0];
    assign m1_ack   = ack_q[1];
    assign m0_err   = err_q[0];
    assign m1_err   = err_q[1];
    assign m0_rdata = m0_rdata_q;
    assign m1_rdata = m1_rdata_q;
    assign s_req    = s_req_q;
    assign s_we     = s_we_q;
    assign s_addr   = s_addr_q;
    assign s_wdata  = s_wdata_q;
    assign busy     = busy_q;
    assign grant    = grant_q;

endmodule

// File: tb/tb_bus_arbiter_xbar.sv
// tb_bus_arbiter_xbar: self-checking bench for bus_arbiter_xbar.
// Slaves ack after a programmable delay; expectations come from a model.
module tb_bus_arbiter_xbar;

    localparam int AW      = 16;
    localparam int DW      = 16;
    localparam int NS      = 6;
    localparam int NSL     = NS + 1;
    localparam int TIMEOUT = 15;
    localparam int NEVER   = 1000;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0]     m0_addr, m1_addr;
    logic [DW-1:0]     m0_wdata, m1_wdata, m0_rdata, m1_rdata;
    logic              m0_ack, m0_err, m1_ack, m1_err;
    logic [NSL-1:0]    s_req, s_ack;
    logic              s_we;
    logic [AW-1:0]     s_addr;
    logic [DW-1:0]     s_wdata;
    logic [NSL*DW-1:0] s_rdata;
    logic              busy, grant;

    logic [DW-1:0]     slot_rd [NSL];
    int                ack_dly [NSL];
    int                acc_cnt;
    logic [NSL-1:0]    noise;
    int                n_pass = 0;
    int                n_chk = 0;

    bus_arbiter_xbar #(
        .AW(AW), .DW(DW), .NS(NS), .PERIPH_PAGE(8'hFF), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_rdata(m0_rdata),
        .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_rdata(m1_rdata),
        .m1_ack(m1_ack), .m1_err(m1_err),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_rdata(s_rdata), .s_ack(s_ack),
        .busy(busy), .grant(grant)
    );

    always #5 clk = ~clk;

    // Slave model: cycles the select has been held, ack at ack_dly.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_cnt <= 0;
        else if (s_req != '0) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end

    always @(negedge clk) noise <= NSL'($urandom);

    // Unselected slots toggle random acks that must be ignored.
    always_comb begin
        for (int k = 0; k < NSL; k++) begin
            s_rdata[k*DW +: DW] = slot_rd[k];
            s_ack[k] = s_req[k] ? (acc_cnt == ack_dly[k]) : noise[k];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    function automatic int exp_slot(input logic [15:0] a);
        if (a[15:8] != 8'hFF) return 0;
        if (int'(a[7:4]) < NS) return int'(a[7:4]) + 1;
        return -1;
    endfunction

    task automatic drive(input int m, input logic r, input logic w,
                         input logic [15:0] a, input logic [15:0] d);
        if (m == 0) begin
            m0_req = r; m0_we = w; m0_addr = a; m0_wdata = d;
        end else begin
            m1_req = r; m1_we = w; m1_addr = a; m1_wdata = d;
        end
    endtask

    task automatic wait_idle();
        @(negedge clk);
        for (int i = 0; i < 50 && busy; i++) @(negedge clk);
    endtask

    task automatic do_txn(input int m, input logic we, input logic [15:0] addr,
                          input logic [15:0] wdata, input int dly,
                          input bit drop, input string tag);
        int slot, exp_lat, exp_cyc, lat, cyc;
        logic exp_err, g_err, my_ack, my_err;
        logic [15:0] exp_rd, g_rd, my_rd, ot_rd;
        logic [NSL-1:0] exp_oh;
        bit ok_stable, ok_quiet, got;
        wait_idle();
        drive(1 - m, 1'b0, 1'b0, 16'h0, 16'h0);
        for (int k = 0; k < NSL; k++) ack_dly[k] = NEVER;
        slot = exp_slot(addr);
        exp_oh = '0;
        if (slot < 0) begin
            exp_lat = 1; exp_err = 1'b1; exp_rd = '0; exp_cyc = 0;
        end else begin
            ack_dly[slot] = dly;
            exp_oh = NSL'(1) << slot;
            if (dly < TIMEOUT) begin
                exp_lat = dly + 2; exp_err = 1'b0; exp_cyc = dly + 1;
                exp_rd = we ? 16'h0 : slot_rd[slot];
            end else begin
                exp_lat = TIMEOUT + 1; exp_err = 1'b1; exp_cyc = TIMEOUT;
                exp_rd = '0;
            end
        end
        drive(m, 1'b1, we, addr, wdata);
        @(posedge clk);
        lat = 0; cyc = 0; ok_stable = 1; ok_quiet = 1; got = 0;
        g_err = 1'b0; g_rd = '0;
        for (int j = 0; j < 300 && !got; j++) begin
            @(negedge clk);
            if (j == 0 && drop)
                drive(m, 1'b0, ~we, 16'($urandom), 16'($urandom));
            my_ack = (m == 0) ? m0_ack : m1_ack;
            my_err = (m == 0) ? m0_err : m1_err;
            my_rd  = (m == 0) ? m0_rdata : m1_rdata;
            ot_rd  = (m == 0) ? m1_rdata : m0_rdata;
            if (((m == 0) ? (m1_ack | m1_err) : (m0_ack | m0_err)) || ot_rd != '0)
                ok_quiet = 0;
            if (!busy || grant != m[0]) ok_stable = 0;
            if (s_req != '0) begin
                cyc++;
                if (s_req !== exp_oh || s_addr !== addr ||
                    s_wdata !== wdata || s_we !== we) ok_stable = 0;
            end
            if (my_ack) begin
                got = 1; lat = j + 1; g_err = my_err; g_rd = my_rd;
                drive(m, 1'b0, we, addr, wdata);
            end else if (my_err || my_rd != '0) begin
                ok_stable = 0;
            end
        end
        if (!got) drive(m, 1'b0, we, addr, wdata);
        n_chk++;
        if (got !== 1'b1) $display("FAIL %s ack_seen: got %0d want 1", tag, got);
        else n_pass++;
        n_chk++;
        if (lat !== exp_lat) $display("FAIL %s latency: got %0d want %0d", tag, lat, exp_lat);
        else n_pass++;
        n_chk++;
        if (g_err !== exp_err) $display("FAIL %s err: got %b want %b", tag, g_err, exp_err);
        else n_pass++;
        n_chk++;
        if (g_rd !== exp_rd) $display("FAIL %s rdata: got %h want %h", tag, g_rd, exp_rd);
        else n_pass++;
        n_chk++;
        if (cyc !== exp_cyc) $display("FAIL %s s_req_cycles: got %0d want %0d", tag, cyc, exp_cyc);
        else n_pass++;
        n_chk++;
        if (ok_stable !== 1'b1) $display("FAIL %s bus_stable: got %0d want 1", tag, ok_stable);
        else n_pass++;
        n_chk++;
        if (ok_quiet !== 1'b1) $display("FAIL %s other_quiet: got %0d want 1", tag, ok_quiet);
        else n_pass++;
    endtask

    task automatic test_reset();
        for (int k = 0; k < NSL; k++) begin
            ack_dly[k] = 0;
            slot_rd[k] = 16'($urandom);
        end
        slot_rd[0] = 16'hBEEF;
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 16'h0123, 16'h1111);
        drive(1, 1'b1, 1'b0, 16'hFF10, 16'h2222);
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if ({m0_ack, m0_err, m0_rdata, m1_ack, m1_err, m1_rdata} !== '0)
            $display("FAIL rst_master_out: got %h want 0",
                     {m0_ack, m0_err, m0_rdata, m1_ack, m1_err, m1_rdata});
        else n_pass++;
        n_chk++;
        if ({s_req, s_we, s_addr, s_wdata} !== '0)
            $display("FAIL rst_slave_out: got %h want 0", {s_req, s_we, s_addr, s_wdata});
        else n_pass++;
        n_chk++;
        if ({busy, grant} !== 2'b00)
            $display("FAIL rst_busy_grant: got %b want 00", {busy, grant});
        else n_pass++;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_chk++;
        if ({grant, s_req} !== {1'b0, 7'b0000001})
            $display("FAIL first_grant: got %b want 0_0000001", {grant, s_req});
        else n_pass++;
    endtask

    // Both masters keep requesting from the reset release onward.
    task automatic test_back_to_back();
        int nack, who, exp_win;
        logic [15:0] rd, exp_rd;
        nack = 0;
        for (int j = 1; j < 40 && nack < 6; j++) begin
            @(posedge clk);
            @(negedge clk);
            if (m0_ack || m1_ack) begin
                who = m1_ack ? 1 : 0;
                rd = m1_ack ? m1_rdata : m0_rdata;
                exp_win = 1 + 3 * nack;
                exp_rd = (nack % 2 == 1) ? slot_rd[2] : slot_rd[0];
                n_chk++;
                if ((m0_ack && m1_ack) || who != nack % 2 || j != exp_win || rd !== exp_rd)
                    $display("FAIL rr_ack%0d: got m%0d@%0d rd=%h want m%0d@%0d rd=%h",
                             nack, who, j, rd, nack % 2, exp_win, exp_rd);
                else n_pass++;
                nack++;
            end
        end
        drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
        n_chk++;
        if (nack !== 6) $display("FAIL rr_count: got %0d want 6", nack);
        else n_pass++;
    endtask

    task automatic test_directed();
        slot_rd[0] = 16'hBEEF;
        slot_rd[1] = 16'h7777;
        do_txn(0, 1'b0, 16'h0123, 16'h0000, 0, 0, "rd_slot0");
        do_txn(1, 1'b1, 16'hFF00, 16'h00A5, 3, 0, "wr_slot1");
        do_txn(0, 1'b0, 16'hFF70, 16'h0000, 0, 0, "unmapped");
        do_txn(1, 1'b1, 16'hFFF3, 16'h1234, 0, 0, "unmapped_top");
        do_txn(0, 1'b0, 16'hFF40, 16'h0000, NEVER, 0, "timeout");
        do_txn(1, 1'b0, 16'hFF40, 16'h0000, TIMEOUT - 1, 0, "ack_last");
        do_txn(0, 1'b1, 16'hFF50, 16'h5A5A, TIMEOUT, 0, "ack_late");
        do_txn(1, 1'b0, 16'h8050, 16'h0000, 2, 1, "drop_req");
    endtask

    task automatic test_reset_mid();
        bit seen;
        wait_idle();
        for (int k = 0; k < NSL; k++) ack_dly[k] = NEVER;
        drive(1, 1'b1, 1'b0, 16'hFF40, 16'h0);
        @(posedge clk);
        @(negedge clk);
        n_chk++;
        if (s_req !== 7'b0100000) $display("FAIL mid_sreq: got %b want 0100000", s_req);
        else n_pass++;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({s_req, busy, m1_ack} !== '0)
            $display("FAIL mid_async: got %b want 0", {s_req, busy, m1_ack});
        else n_pass++;
        drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
        seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (m0_ack | m1_ack | m0_err | m1_err) seen = 1;
        end
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (m0_ack | m1_ack | m0_err | m1_err) seen = 1;
        end
        n_chk++;
        if (seen !== 1'b0) $display("FAIL mid_no_ack: got %0d want 0", seen);
        else n_pass++;
        do_txn(1, 1'b0, 16'h0042, 16'h0, 1, 0, "post_reset");
        do_txn(0, 1'b0, 16'hFF40, 16'h0, NEVER, 0, "post_reset_tmo");
    endtask

    task automatic test_random();
        logic [15:0] a;
        int dly;
        string tag;
        for (int i = 0; i < 30; i++) begin
            for (int k = 0; k < NSL; k++) slot_rd[k] = 16'($urandom);
            case ($urandom_range(0, 2))
                0: a = {8'($urandom_range(0, 254)), 8'($urandom)};
                1: a = {8'hFF, 4'($urandom_range(0, 15)), 4'($urandom)};
                default: a = 16'($urandom);
            endcase
            dly = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(0, 4));
            tag = $sformatf("rand%0d", i);
            do_txn(int'($urandom_range(0, 1)), 1'($urandom), a, 16'($urandom),
                   dly, 1'($urandom), tag);
        end
    endtask

    initial begin
        drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
        for (int k = 0; k < NSL; k++) begin
            ack_dly[k] = NEVER;
            slot_rd[k] = '0;
        end
        test_reset();
        test_back_to_back();
        test_directed();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
